// File: rtl/hex_io_mux_pkg.sv
// Shared constants and types for the IO-mapped multiplexed hex display.
// Register offsets, CTRL bit positions, blank pattern and IO window helper.
package hex_io_mux_pkg;

  localparam logic [3:0] OFF_DATA_LO = 4'd0;
  localparam logic [3:0] OFF_DATA_HI = 4'd1;
  localparam logic [3:0] OFF_CTRL    = 4'd2;

  localparam int CTRL_BLINK = 8;
  localparam int CTRL_MODE  = 9;
  localparam int CTRL_W     = 10;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam int         IO_WINDOW = 16;

  typedef struct packed {
    logic       mode;
    logic       blink;
    logic [7:0] blank;
  } ctrl_t;

  // Widened compare so a window near the top of the page does not wrap.
  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
    logic [8:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (diff < 9'(IO_WINDOW));
  endfunction

endpackage

// File: rtl/hex_io_mux_if.sv
// IO bus bundle between the CPU-side IO decoder and an IO peripheral.
interface hex_io_mux_if;
  logic        i_IO_we;
  logic        i_IO_re;
  logic [7:0]  i_IO_addr;
  logic [15:0] i_IO_data;
  logic [15:0] o_IO_data;
  logic        o_IO_hit;

  modport master (
    output i_IO_we, i_IO_re, i_IO_addr, i_IO_data,
    input  o_IO_data, o_IO_hit
  );

  modport slave (
    input  i_IO_we, i_IO_re, i_IO_addr, i_IO_data,
    output o_IO_data, o_IO_hit
  );
endinterface

// File: rtl/hex_io_mux_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder (bit0=a .. bit6=g).
module hex_seg7
  import hex_io_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/hex_io_mux.sv
// IO-mapped hex display: up to 8 digit registers, time-multiplexed scan, blank/blink, readback.
// Optional HEX_STATIC_OUT_EN adds o_hex with all digits decoded in parallel.
module hex_io_mux
  import hex_io_mux_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] BASE_ADDR  = 8'h80,
  parameter int         SCAN_DIV   = 50000,
  parameter int         BLINK_DIV  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_io_mux_if.slave           bus,
  input  logic [15:0]           i_RAM_data,
  output logic [6:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_dig_sel
`ifdef HEX_STATIC_OUT_EN
  , output logic [7*NUM_DIGITS-1:0] o_hex
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [15:0]           data_lo_reg;
  logic [15:0]           data_hi_reg;
  ctrl_t                 ctrl_reg;
  logic [PRE_W-1:0]      pre_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [BLK_W-1:0]      blk_cnt_reg;
  logic                  blink_phase_reg;
  logic [15:0]           rdata_reg;
  logic                  hit_reg;
  logic [6:0]            seg_reg;
  logic [NUM_DIGITS-1:0] dig_sel_reg;

  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [3:0]  off;
  logic [15:0] rd_val;
  logic [15:0] shown_lo;

  assign hit   = in_window(bus.i_IO_addr, BASE_ADDR);
  assign off   = 4'(bus.i_IO_addr - BASE_ADDR);
  assign wr_en = hit & bus.i_IO_we;
  assign rd_en = hit & bus.i_IO_re;
  assign tick  = (pre_reg == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA_LO: rd_val = data_lo_reg;
      OFF_DATA_HI: rd_val = data_hi_reg;
      OFF_CTRL:    rd_val = {{(16 - CTRL_W){1'b0}}, ctrl_reg};
      default:     rd_val = '0;
    endcase
  end

  // Readback samples the pre-write value, so a same-cycle write/read returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_lo_reg <= '0;
      data_hi_reg <= '0;
      ctrl_reg    <= '0;
      rdata_reg   <= '0;
      hit_reg     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (off)
          OFF_DATA_LO: data_lo_reg <= bus.i_IO_data;
          OFF_DATA_HI: data_hi_reg <= bus.i_IO_data;
          OFF_CTRL:    ctrl_reg    <= ctrl_t'(bus.i_IO_data[CTRL_W-1:0]);
          default: ;
        endcase
      end
      hit_reg <= rd_en;
      if (rd_en) rdata_reg <= rd_val;
    end
  end

  assign bus.o_IO_data = rdata_reg;
  assign bus.o_IO_hit  = hit_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg         <= '0;
      idx_reg         <= '0;
      blk_cnt_reg     <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
      if (tick) idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      if (!ctrl_reg.blink) begin
        blk_cnt_reg     <= '0;
        blink_phase_reg <= 1'b0;
      end else if (tick) begin
        if (blk_cnt_reg == BLK_W'(BLINK_DIV - 1)) begin
          blk_cnt_reg     <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
        end
      end
    end
  end

  // Live mode substitutes the RAM word only for the low four digits.
  assign shown_lo = ctrl_reg.mode ? i_RAM_data : data_lo_reg;

  logic [3:0] nib  [NUM_DIGITS];
  logic       dark [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi < 4) begin : g_lo
      assign nib[gi] = shown_lo[4*gi +: 4];
    end else begin : g_hi
      assign nib[gi] = data_hi_reg[4*(gi-4) +: 4];
    end
    assign dark[gi] = ctrl_reg.blank[gi] | (ctrl_reg.blink & blink_phase_reg);
  end

  logic [3:0]            sel_nib;
  logic                  sel_dark;
  logic [6:0]            sel_seg;
  logic [NUM_DIGITS-1:0] dig_sel_next;

  always_comb begin
    sel_nib      = '0;
    sel_dark     = 1'b0;
    dig_sel_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sel_nib         = nib[i];
        sel_dark        = dark[i];
        dig_sel_next[i] = 1'b0;
      end
    end
  end

  hex_seg7 u_mux_dec (
    .nibble (sel_nib),
    .seg    (sel_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_reg     <= SEG_OFF;
      dig_sel_reg <= '1;
    end else begin
      seg_reg     <= sel_dark ? SEG_OFF : sel_seg;
      dig_sel_reg <= dig_sel_next;
    end
  end

  assign o_seg     = seg_reg;
  assign o_dig_sel = dig_sel_reg;

`ifdef HEX_STATIC_OUT_EN
  logic [7*NUM_DIGITS-1:0] hex_reg;
  logic [7*NUM_DIGITS-1:0] hex_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_static
    logic [6:0] dig_seg;
    hex_seg7 u_dec (
      .nibble (nib[gi]),
      .seg    (dig_seg)
    );
    assign hex_next[7*gi +: 7] = dark[gi] ? SEG_OFF : dig_seg;
  end

  always_ff @(posedge clk) begin
    if (reset) hex_reg <= '1;
    else       hex_reg <= hex_next;
  end

  assign o_hex = hex_reg;
`endif

endmodule
